uart_io_controller: RTL

- Memory-mapped UART peripheral that occupies one device slot of the I/O decode logic (bus fields: we, reg_sel, cs, 16-bit in/out).
- Sequences a TX shifter fed by a 4-entry FIFO, and an RX deserializer with a 1-byte holding register.
- Provides status and error flags and a runtime-programmable baud divisor, so the CPU can transmit and receive serial data with polled I/O.

---
 rtl/uart_io_controller.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_io_controller.sv
// Polled UART slot: 4-deep TX FIFO feeding an 8N1 shifter, RX deserializer with 1-byte holding register.
// Latency: TX line drops 2 cycles after a DATA write; writes into a full FIFO are dropped and flag tx_overflow.

// Generic FIFO: 1-cycle write-to-read latency; wr_rdy drops when full unless a read frees a slot this cycle.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_vld,
  output logic                     wr_rdy,
  input  logic [W-1:0]             wr_dat,
  output logic                     rd_vld,
  input  logic                     rd_rdy,
  output logic [W-1:0]             rd_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_wr;
  logic          do_rd;

  assign rd_vld = (count != '0);
  assign do_rd  = rd_vld && rd_rdy;
  assign wr_rdy = (count != (AW+1)'(DEPTH)) || do_rd;
  assign do_wr  = wr_vld && wr_rdy;
  assign rd_dat = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end
endmodule

module uart_io_controller #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TX_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  reg_sel,
  input  logic        cs,
  input  logic [15:0] in,
  output logic [15:0] out,
  input  logic        rx,
  output logic        tx
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic        wr_en;
  logic        ctrl_wr;
  logic        clr_valid;
  logic        clr_err;
  logic [15:0] baud;

  assign wr_en     = cs && we;
  assign ctrl_wr   = wr_en && (reg_sel == 2'd3);
  assign clr_valid = ctrl_wr && in[0];
  assign clr_err   = ctrl_wr && in[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) baud <= 16'(CLKS_PER_BIT);
    else if (wr_en && reg_sel == 2'd2) baud <= (in < 16'd4) ? 16'd4 : in;
  end

  // TX: FIFO pops on the same edge the shifter leaves IDLE
  state_t      tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shr;
  logic        tx_overflow;
  logic        push;
  logic        fifo_wr_rdy;
  logic        fifo_rd_vld;
  logic        fifo_rd_rdy;
  logic [7:0]  fifo_rd_dat;
  logic [2:0]  fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        tx_busy;

  assign push        = wr_en && (reg_sel == 2'd0);
  assign fifo_rd_rdy = (tx_state == S_IDLE);
  assign fifo_full   = (fifo_count == 3'(TX_DEPTH));
  assign fifo_empty  = !fifo_rd_vld;
  assign tx_busy     = (tx_state != S_IDLE);

  fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (push),
    .wr_rdy (fifo_wr_rdy),
    .wr_dat (in[7:0]),
    .rd_vld (fifo_rd_vld),
    .rd_rdy (fifo_rd_rdy),
    .rd_dat (fifo_rd_dat),
    .count  (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shr   <= '0;
      tx       <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          tx <= 1'b1;
          if (fifo_rd_vld) begin
            tx_shr   <= fifo_rd_dat;
            tx       <= 1'b0;
            tx_cnt   <= baud - 16'd1;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == '0) begin
            tx       <= tx_shr[0];
            tx_shr   <= {1'b0, tx_shr[7:1]};
            tx_bit   <= '0;
            tx_cnt   <= baud - 16'd1;
            tx_state <= S_DATA;
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        S_DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt <= baud - 16'd1;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx     <= tx_shr[0];
              tx_shr <= {1'b0, tx_shr[7:1]};
              tx_bit <= tx_bit + 3'd1;
            end
          end else tx_cnt <= tx_cnt - 16'd1;
        end
        default: begin
          if (tx_cnt == '0) tx_state <= S_IDLE;
          else tx_cnt <= tx_cnt - 16'd1;
        end
      endcase
    end
  end

  // RX
  state_t      rx_state;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shr;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_overrun;
  logic        frame_err;
  logic        rx_done;
  logic        rx_load;
  logic        overrun_set;
  logic        ferr_set;
  logic        ovf_set;

  assign rx_done     = (rx_state == S_STOP) && (rx_cnt == '0);
  // A CTRL clear landing with a completed byte frees the holding register for it
  assign rx_load     = rx_done && rx_s2 && (!rx_valid || clr_valid);
  assign overrun_set = rx_done && rx_s2 && rx_valid && !clr_valid;
  assign ferr_set    = rx_done && !rx_s2;
  assign ovf_set     = push && !fifo_wr_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shr   <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        S_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_cnt   <= (baud >> 1) - 16'd1;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == '0) begin
            rx_cnt   <= baud - 16'd1;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        S_DATA: begin
          if (rx_cnt == '0) begin
            rx_shr <= {rx_s2, rx_shr[7:1]};
            rx_cnt <= baud - 16'd1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else rx_bit <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt - 16'd1;
        end
        default: begin
          if (rx_cnt == '0) rx_state <= S_IDLE;
          else rx_cnt <= rx_cnt - 16'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      frame_err   <= 1'b0;
      tx_overflow <= 1'b0;
    end else begin
      if (rx_load) rx_byte <= rx_shr;
      rx_valid    <= rx_load || (rx_valid && !clr_valid);
      rx_overrun  <= overrun_set || (rx_overrun && !clr_err);
      frame_err   <= ferr_set || (frame_err && !clr_err);
      tx_overflow <= ovf_set || (tx_overflow && !clr_err);
    end
  end

  always_comb begin
    out = 16'h0000;
    case (reg_sel)
      2'd0: out = {8'h00, rx_byte};
      2'd1: out = {5'b0, fifo_count, 1'b0, tx_overflow, frame_err, rx_overrun,
                   tx_busy, fifo_empty, fifo_full, rx_valid};
      2'd2: out = baud;
      default: out = 16'h0000;
    endcase
  end
endmodule
